// File: rtl/level_display_pkg.sv
// level_display_pkg
//   Shared types and segment constants for the level display.
//   Segment encoding is {g,f,e,d,c,b,a}, active-low (common-anode).
package level_display_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  localparam seg_t SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic is_bcd(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/level_display_bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD to active-low 7-segment decoder.
//   Ports:
//     bcd : BCD digit in
//     seg : segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD gives a dash
module bcd_to_seg7
  import level_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (is_bcd(bcd)) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/level_display.sv
// level_display
//   Throttled 4-digit multiplexed common-anode 7-segment display for the
//   output-level meter. Digit 3 shows the sign, digits 2..0 the magnitude.
//   Ports:
//     clk      : sample-rate clock
//     reset_n  : synchronous active-low reset
//     num2..0  : BCD hundreds/tens/units from the level meter
//     neg      : level is negative
//     seg_n    : segments {g,f,e,d,c,b,a}, active-low
//     an_n     : digit enables, active-low; an_n[3] is the sign digit
//     overload : latched value contains a non-BCD digit
//   Build option:
//     LEVEL_DISPLAY_PEAK_HOLD_EN : latch the signed peak of each hold window
//                                  instead of the last sample.
module level_display
  import level_display_pkg::*;
#(
  parameter int SCAN_DIV    = 24,
  parameter int HOLD_CYCLES = 4800
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  input  logic       neg,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       overload
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  digit_idx_t        idx;

  bcd_t lat2, lat1, lat0;
  logic lat_neg;

  // Value presented to the latch at the end of a hold window.
  bcd_t nxt2, nxt1, nxt0;
  logic nxt_neg, nxt_bad;

  logic hold_end;
  assign hold_end = (hold_cnt == HOLD_LAST);

`ifdef LEVEL_DISPLAY_PEAK_HOLD_EN
  logic [10:0]        cur_mag;
  logic signed [11:0] cur_val, pk_val;
  logic               cur_bad;
  bcd_t               pk2, pk1, pk0;
  logic               pk_neg, pk_bad, pk_valid;
  logic               take_cur;

  assign cur_mag = 11'(num2) * 11'd100 + 11'(num1) * 11'd10 + 11'(num0);
  assign cur_val = neg ? -signed'({1'b0, cur_mag}) : signed'({1'b0, cur_mag});
  assign cur_bad = !(is_bcd(num2) && is_bcd(num1) && is_bcd(num0));
  // The first window after reset has no history, so the live sample wins.
  assign take_cur = !pk_valid || (cur_val > pk_val);

  always_comb begin
    nxt2    = take_cur ? num2 : pk2;
    nxt1    = take_cur ? num1 : pk1;
    nxt0    = take_cur ? num0 : pk0;
    nxt_neg = take_cur ? neg  : pk_neg;
    nxt_bad = cur_bad || (pk_valid && pk_bad);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pk_val   <= '0;
      pk2      <= '0;
      pk1      <= '0;
      pk0      <= '0;
      pk_neg   <= 1'b0;
      pk_bad   <= 1'b0;
      pk_valid <= 1'b0;
    end else if (hold_end) begin
      // Window closes: restart tracking from the live sample.
      pk_val   <= cur_val;
      pk2      <= num2;
      pk1      <= num1;
      pk0      <= num0;
      pk_neg   <= neg;
      pk_bad   <= cur_bad;
      pk_valid <= 1'b1;
    end else begin
      if (take_cur) begin
        pk_val <= cur_val;
        pk2    <= num2;
        pk1    <= num1;
        pk0    <= num0;
        pk_neg <= neg;
      end
      pk_bad   <= pk_bad || cur_bad;
      pk_valid <= 1'b1;
    end
  end
`else
  always_comb begin
    nxt2    = num2;
    nxt1    = num1;
    nxt0    = num0;
    nxt_neg = neg;
    nxt_bad = !(is_bcd(num2) && is_bcd(num1) && is_bcd(num0));
  end
`endif

  // Digit select, leading-zero blanking, sign and overload overrides.
  bcd_t sel_bcd;
  seg_t dec_seg, slot_seg, force_seg;
  logic force_on, mag_zero;

  assign mag_zero = (lat2 == 4'd0) && (lat1 == 4'd0) && (lat0 == 4'd0);

  bcd_to_seg7 u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    sel_bcd   = lat0;
    force_on  = 1'b0;
    force_seg = SEG_BLANK;
    case (idx)
      2'd0: sel_bcd = lat0;
      2'd1: begin
        sel_bcd  = lat1;
        force_on = (lat2 == 4'd0) && (lat1 == 4'd0);
      end
      2'd2: begin
        sel_bcd  = lat2;
        force_on = (lat2 == 4'd0);
      end
      default: begin
        force_on  = 1'b1;
        force_seg = (lat_neg && !mag_zero) ? SEG_DASH : SEG_BLANK;
      end
    endcase
    // Overload replaces every magnitude digit; the sign digit is unaffected.
    if (overload && idx != 2'd3) begin
      force_on  = 1'b1;
      force_seg = SEG_DASH;
    end
    slot_seg = force_on ? force_seg : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_n    <= SEG_BLANK;
      an_n     <= 4'hF;
      overload <= 1'b0;
      lat2     <= '0;
      lat1     <= '0;
      lat0     <= '0;
      lat_neg  <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      hold_cnt <= HOLD_LAST;
    end else begin
      // First clock of every slot is dark to stop ghosting between digits.
      if (scan_cnt == '0) begin
        an_n  <= 4'hF;
        seg_n <= SEG_BLANK;
      end else begin
        an_n  <= ~(4'b0001 << idx);
        seg_n <= slot_seg;
      end

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      if (hold_end) begin
        hold_cnt <= '0;
        lat2     <= nxt2;
        lat1     <= nxt1;
        lat0     <= nxt0;
        lat_neg  <= nxt_neg;
        overload <= nxt_bad;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule
